// File: rtl/ble6_cfg_sequencer.sv
// Bit-serial configuration sequencer for the BLE6 bl/wl memory: one cell per
// WL_PULSE+1 cycles. Define BLE6_CFG_PARITY_EN for an even-parity MSB on cfg_data.
module ble6_cfg_sequencer #(
    parameter int unsigned NUM_BITS = 66,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WL_PULSE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                cfg_valid,
`ifdef BLE6_CFG_PARITY_EN
    input  logic [DATA_W:0]     cfg_data,
`else
    input  logic [DATA_W-1:0]   cfg_data,
`endif
    output logic                cfg_ready,
    output logic [0:NUM_BITS-1] bl,
    output logic [0:NUM_BITS-1] wl,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_error
);
    localparam int unsigned AW = $clog2(NUM_BITS);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, PULSE, HOLD, DONE} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [3:0]          pcnt_q, pcnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [0:NUM_BITS-1] bl_q, bl_d, wl_q, wl_d;
    logic                ready_q, ready_d, busy_q, busy_d;
    logic                done_q, done_d, err_q, err_d;
    logic                accept, parity_bad;

    assign accept = (state_q == FETCH) && cfg_valid && ready_q;

`ifdef BLE6_CFG_PARITY_EN
    assign parity_bad = ^cfg_data;
`else
    assign parity_bad = 1'b0;
`endif

    // Outputs are computed from the next state so bl/wl leave flops directly.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bit_idx_d = bit_idx_q;
        pcnt_d    = pcnt_q;
        word_d    = word_q;
        bl_d      = bl_q;
        wl_d      = '0;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                bl_d = '0;
                if (cfg_start) begin
                    state_d   = FETCH;
                    addr_d    = '0;
                    bit_idx_d = '0;
                    err_d     = 1'b0;
                end
            end
            FETCH: begin
                bl_d = '0;
                if (accept) begin
                    if (parity_bad) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        word_d          = cfg_data[DATA_W-1:0];
                        bit_idx_d       = '0;
                        pcnt_d          = '0;
                        state_d         = PULSE;
                        bl_d[addr_q]    = cfg_data[0];
                        wl_d[addr_q]    = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (pcnt_q == 4'(WL_PULSE - 1)) begin
                    state_d = HOLD;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                    wl_d   = wl_q;
                end
            end
            HOLD: begin
                if (addr_q == AW'(NUM_BITS - 1)) begin
                    state_d = DONE;
                    bl_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + AW'(1);
                    pcnt_d = '0;
                    bl_d   = '0;
                    if (bit_idx_q == BW'(DATA_W - 1)) begin
                        bit_idx_d = '0;
                        state_d   = FETCH;
                    end else begin
                        bit_idx_d       = bit_idx_q + BW'(1);
                        state_d         = PULSE;
                        bl_d[addr_d]    = word_q[bit_idx_d];
                        wl_d[addr_d]    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                bl_d    = '0;
            end
            default: state_d = IDLE;
        endcase
        if (cfg_abort && state_q != IDLE) begin
            state_d = IDLE;
            bl_d    = '0;
            wl_d    = '0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
        ready_d = (state_d == FETCH);
        busy_d  = state_d inside {FETCH, PULSE, HOLD};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            bit_idx_q <= '0;
            pcnt_q    <= '0;
            word_q    <= '0;
            bl_q      <= '0;
            wl_q      <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_idx_q <= bit_idx_d;
            pcnt_q    <= pcnt_d;
            word_q    <= word_d;
            bl_q      <= bl_d;
            wl_q      <= wl_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bl        = bl_q;
    assign wl        = wl_q;
    assign cfg_ready = ready_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_error = err_q;
endmodule

// File: tb/tb_ble6_cfg_sequencer.sv
// Bench for ble6_cfg_sequencer: word table drives passes, a scoreboard checks
// every wl pulse. BLE6_CFG_PARITY_EN adds the bad-parity sequence.
module tb_ble6_cfg_sequencer;
    localparam int unsigned NB  = 66;
    localparam int unsigned DW  = 8;
    localparam int unsigned WP  = 2;
    localparam int          LIM = 400;
`ifdef BLE6_CFG_PARITY_EN
    localparam int unsigned DIN_W = DW + 1;
`else
    localparam int unsigned DIN_W = DW;
`endif

    logic             clk, reset, cfg_start, cfg_abort, cfg_valid;
    logic [DIN_W-1:0] cfg_data;
    logic             cfg_ready, cfg_busy, cfg_done, cfg_error;
    logic [0:NB-1]    bl, wl;

    typedef struct {
        logic [7:0]  data;
        logic [0:7]  exp_bl;
        int unsigned ncells;
    } vec_t;

    typedef struct {
        int unsigned addr;
        logic        bit_v;
    } exp_t;

    vec_t          tbl[9];
    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            t0 = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            pulse_len = 0;
    bit            mon_en = 0;
    logic [0:NB-1] wl_prev = '0;
    logic [0:NB-1] bl_prev = '0;

    ble6_cfg_sequencer #(
        .NUM_BITS(NB),
        .DATA_W  (DW),
        .WL_PULSE(WP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_start(cfg_start),
        .cfg_abort(cfg_abort),
        .cfg_valid(cfg_valid),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .bl       (bl),
        .wl       (wl),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DIN_W-1:0] mk_word(input logic [DW-1:0] d);
`ifdef BLE6_CFG_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always @(negedge clk) begin
        int   idx;
        exp_t e;
        if (mon_en) begin
            chk("wl_onehot", 128'($countones(wl) <= 1), 128'(1));
            if (wl != '0 && wl != wl_prev) begin
                idx = 0;
                for (int i = 0; i < NB; i++) if (wl[i]) idx = i;
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_pulse", 128'(idx), 128'(NB));
                end else begin
                    e = sbq.pop_front();
                    chk("sb_addr", 128'(idx), 128'(e.addr));
                    chk("sb_bl", 128'(bl[idx]), 128'(e.bit_v));
                    chk("bl_other_zero", 128'(bl & ~wl), 128'(0));
                end
            end
            if (wl == '0 && wl_prev != '0) begin
                chk("pulse_len", 128'(pulse_len), 128'(WP));
                chk("bl_stable_fall", 128'(bl), 128'(bl_prev));
            end
        end
        if (cfg_done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc - t0 + 1;
        end
        if (wl != '0 && wl == wl_prev) pulse_len++;
        else if (wl != '0) pulse_len = 1;
        wl_prev = wl;
        bl_prev = bl;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cfg_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(cfg_ready), 128'(1));
    endtask

    task automatic wait_wl(input int a, input string name);
        int n = 0;
        while (!wl[a] && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(wl[a]), 128'(1));
    endtask

    task automatic start_pass();
        done_cnt  = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        t0        = cyc;
        chk("start_busy", 128'(cfg_busy), 128'(1));
        chk("start_err_clear", 128'(cfg_error), 128'(0));
    endtask

    task automatic do_pass(input int stall_idx, input int stall_n, input int abort_addr,
                           input int g1, input int g2, input bit chk_lat);
        int n;
        mon_en = 1'b1;
        start_pass();
        for (int w = 0; w < 9; w++) begin
            if (w == stall_idx) begin
                cfg_valid = 1'b0;
                wait_ready("stall_enter");
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_ready", 128'(cfg_ready), 128'(1));
                    chk("stall_wl", 128'(wl), 128'(0));
                end
            end
            cfg_data = mk_word(tbl[w].data);
            for (int i = 0; i < int'(tbl[w].ncells); i++)
                sbq.push_back('{addr: w * 8 + i, bit_v: tbl[w].exp_bl[i]});
            cfg_valid = 1'b1;
            wait_ready("word_ready");
            tick();
            if (w == 8) cfg_valid = 1'b0;
            if (g1 >= w * 8 && g1 < w * 8 + 8) begin
                wait_wl(g1, "glitch1_wait");
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
            end
            if (g2 >= w * 8 && g2 < w * 8 + 8) begin
                wait_wl(g2, "glitch2_wait");
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
            end
            if (abort_addr >= w * 8 && abort_addr < w * 8 + 8) begin
                wait_wl(abort_addr, "abort_wait");
                mon_en    = 1'b0;
                cfg_abort = 1'b1;
                tick();
                cfg_abort = 1'b0;
                cfg_valid = 1'b0;
                @(negedge clk);
                chk("abort_wl", 128'(wl), 128'(0));
                chk("abort_bl", 128'(bl), 128'(0));
                chk("abort_busy", 128'(cfg_busy), 128'(0));
                chk("abort_err", 128'(cfg_error), 128'(1));
                chk("abort_ready", 128'(cfg_ready), 128'(0));
                repeat (10) @(negedge clk);
                chk("abort_no_done", 128'(done_cnt), 128'(0));
                chk("abort_err_sticky", 128'(cfg_error), 128'(1));
                sbq.delete();
                return;
            end
        end
        n = 0;
        while (done_cnt == 0 && n < LIM) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (5) @(negedge clk);
        chk("done_once", 128'(done_cnt), 128'(1));
        if (chk_lat) chk("done_latency", 128'(done_cyc), 128'(208));
        chk("sb_empty", 128'(sbq.size()), 128'(0));
        chk("end_err", 128'(cfg_error), 128'(0));
        chk("end_busy", 128'(cfg_busy), 128'(0));
        chk("end_bl", 128'(bl), 128'(0));
    endtask

`ifdef BLE6_CFG_PARITY_EN
    task automatic parity_pass();
        logic [DW-1:0] d;
        mon_en = 1'b1;
        start_pass();
        cfg_data = mk_word(tbl[0].data);
        for (int i = 0; i < 8; i++) sbq.push_back('{addr: i, bit_v: tbl[0].exp_bl[i]});
        cfg_valid = 1'b1;
        wait_ready("par_w0_ready");
        tick();
        d         = tbl[1].data;
        cfg_data  = {~(^d), d};
        wait_ready("par_w1_ready");
        tick();
        cfg_valid = 1'b0;
        chk("par_err", 128'(cfg_error), 128'(1));
        chk("par_busy", 128'(cfg_busy), 128'(0));
        repeat (30) @(negedge clk);
        chk("par_sb_empty", 128'(sbq.size()), 128'(0));
        chk("par_no_done", 128'(done_cnt), 128'(0));
        chk("par_wl_idle", 128'(wl), 128'(0));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hA5, 8'b10100101, 8};
        tbl[1] = '{8'h00, 8'b00000000, 8};
        tbl[2] = '{8'hFF, 8'b11111111, 8};
        tbl[3] = '{8'h3C, 8'b00111100, 8};
        tbl[4] = '{8'h81, 8'b10000001, 8};
        tbl[5] = '{8'h7E, 8'b01111110, 8};
        tbl[6] = '{8'h01, 8'b10000000, 8};
        tbl[7] = '{8'h80, 8'b00000001, 8};
        tbl[8] = '{8'h02, 8'b01000000, 2};

        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        #2 reset  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bl", 128'(bl), 128'(0));
        chk("rst_wl", 128'(wl), 128'(0));
        chk("rst_ready", 128'(cfg_ready), 128'(0));
        chk("rst_busy", 128'(cfg_busy), 128'(0));
        chk("rst_done", 128'(cfg_done), 128'(0));
        chk("rst_err", 128'(cfg_error), 128'(0));
        tick();
        reset = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_err", 128'(cfg_error), 128'(0));
        chk("idle_ready", 128'(cfg_ready), 128'(0));
        tick();

        do_pass(-1, 0, -1, -1, -1, 1'b1);
        do_pass(2, 20, -1, -1, -1, 1'b0);
        do_pass(-1, 0, 37, -1, -1, 1'b0);
        do_pass(-1, 0, -1, 10, 50, 1'b0);
`ifdef BLE6_CFG_PARITY_EN
        parity_pass();
`endif

        mon_en = 1'b0;
        start_pass();
        cfg_data  = mk_word(8'h55);
        cfg_valid = 1'b1;
        wait_ready("rst_mid_ready");
        tick();
        cfg_valid = 1'b0;
        wait_wl(5, "rst_mid_wait");
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_wl", 128'(wl), 128'(0));
        chk("rst_mid_bl", 128'(bl), 128'(0));
        chk("rst_mid_ready", 128'(cfg_ready), 128'(0));
        chk("rst_mid_busy", 128'(cfg_busy), 128'(0));
        chk("rst_mid_done", 128'(cfg_done), 128'(0));
        chk("rst_mid_err", 128'(cfg_error), 128'(0));
        #4 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", 128'(cfg_ready), 128'(0));
        chk("post_rst_busy", 128'(cfg_busy), 128'(0));
        chk("post_rst_wl", 128'(wl), 128'(0));
        sbq.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
